// File: rtl/axis_frame_arbiter.sv
// ---------------------------------------------------------------------------
// axis_frame_arbiter
//
// Purpose:
//   Two-input AXI-Stream frame arbiter feeding one shared output stream.
//   Whole frames are granted to one requester at a time (never interleaved).
//   A requester that wins arbitration owns the output until its tlast beat.
//   Ties are broken round-robin against the previous owner. Frames longer
//   than MAX_BEATS are cut: the MAX_BEATS-th beat is sent with tlast forced
//   high, and the remainder of the source frame is drained and discarded.
//
// Ports:
//   s_axis_aclk      : single clock, rising edge
//   s_axis_areset    : asynchronous, active-high reset
//   s0_axis_*        : requester 0 stream (tdata/tvalid/tlast in, tready out)
//   s1_axis_*        : requester 1 stream (tdata/tvalid/tlast in, tready out)
//   m_axis_*         : shared output stream (tdata/tvalid/tlast out, tready in)
//   grant            : one-hot current owner, bit0 = s0, bit1 = s1, 00 = none
//   status_frame_cnt0/1 : frames forwarded per source (wrapping)
//   status_trunc     : one-cycle pulse after a frame has been truncated
// ---------------------------------------------------------------------------
module axis_frame_arbiter #(
  parameter int DATA_WIDTH = 64,
  parameter int MAX_BEATS  = 256,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  s_axis_aclk,
  input  logic                  s_axis_areset,

  input  logic [DATA_WIDTH-1:0] s0_axis_tdata,
  input  logic                  s0_axis_tvalid,
  input  logic                  s0_axis_tlast,
  output logic                  s0_axis_tready,

  input  logic [DATA_WIDTH-1:0] s1_axis_tdata,
  input  logic                  s1_axis_tvalid,
  input  logic                  s1_axis_tlast,
  output logic                  s1_axis_tready,

  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,

  output logic [1:0]            grant,
  output logic [CNT_WIDTH-1:0]  status_frame_cnt0,
  output logic [CNT_WIDTH-1:0]  status_frame_cnt1,
  output logic                  status_trunc
);

  localparam int BEAT_W = $clog2(MAX_BEATS + 1);
  // Beat counter value while the MAX_BEATS-th beat of a frame is on the bus.
  localparam logic [BEAT_W-1:0] LAST_BEAT_IDX = BEAT_W'(MAX_BEATS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // ---------------------------------------------------------------------
  // Registers and their next-state values
  // ---------------------------------------------------------------------
  state_t                r_state;
  state_t                w_state_next;
  logic [1:0]            r_grant;
  logic [1:0]            w_grant_next;
  // Previous owner: 0 = s0, 1 = s1.
  logic                  r_last_grant;
  logic                  w_last_grant_next;
  logic [BEAT_W-1:0]     r_beat_cnt;
  logic [BEAT_W-1:0]     w_beat_cnt_next;
  logic [CNT_WIDTH-1:0]  r_frame_cnt0;
  logic [CNT_WIDTH-1:0]  r_frame_cnt1;
  logic                  r_trunc;
  logic                  w_trunc_next;
  logic                  w_frame_done;

  // ---------------------------------------------------------------------
  // Granted-source view. Only meaningful outside IDLE, where r_grant is
  // one-hot; bit 1 alone therefore identifies the owner.
  // ---------------------------------------------------------------------
  logic                  w_owner_s1;
  logic [DATA_WIDTH-1:0] w_src_data;
  logic                  w_src_valid;
  logic                  w_src_last;
  logic                  w_at_max;
  logic                  w_sel_s1;

  assign w_owner_s1  = r_grant[1];
  assign w_src_data  = w_owner_s1 ? s1_axis_tdata  : s0_axis_tdata;
  assign w_src_valid = w_owner_s1 ? s1_axis_tvalid : s0_axis_tvalid;
  assign w_src_last  = w_owner_s1 ? s1_axis_tlast  : s0_axis_tlast;
  assign w_at_max    = (r_beat_cnt == LAST_BEAT_IDX);

  // IDLE selection: a lone requester wins; on a tie the requester that did
  // not own the previous frame wins.
  assign w_sel_s1 = s1_axis_tvalid & (~s0_axis_tvalid | ~r_last_grant);

  // Data path is a pure mux; tvalid gates its meaning.
  assign m_axis_tdata = w_src_data;

  // ---------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------
  always_comb begin
    w_state_next      = r_state;
    w_grant_next      = r_grant;
    w_last_grant_next = r_last_grant;
    w_beat_cnt_next   = r_beat_cnt;
    w_trunc_next      = 1'b0;
    w_frame_done      = 1'b0;
    m_axis_tvalid     = 1'b0;
    m_axis_tlast      = 1'b0;
    s0_axis_tready    = 1'b0;
    s1_axis_tready    = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        // Arbitration bubble: nothing is accepted or presented this cycle.
        if (s0_axis_tvalid || s1_axis_tvalid) begin
          w_grant_next = w_sel_s1 ? 2'b10 : 2'b01;
          w_state_next = ST_BUSY;
        end
      end

      ST_BUSY: begin
        m_axis_tvalid  = w_src_valid;
        // Forced tlast on the final allowed beat closes the output frame
        // even though the source frame continues.
        m_axis_tlast   = w_src_last | w_at_max;
        s0_axis_tready = ~w_owner_s1 & m_axis_tready;
        s1_axis_tready =  w_owner_s1 & m_axis_tready;

        if (w_src_valid && m_axis_tready) begin
          if (w_src_last) begin
            w_state_next      = ST_IDLE;
            w_grant_next      = 2'b00;
            w_last_grant_next = w_owner_s1;
            w_beat_cnt_next   = '0;
            w_frame_done      = 1'b1;
          end else if (w_at_max) begin
            w_state_next      = ST_DRAIN;
            w_beat_cnt_next   = '0;
            w_trunc_next      = 1'b1;
            w_frame_done      = 1'b1;
          end else begin
            w_beat_cnt_next   = r_beat_cnt + BEAT_W'(1);
          end
        end
      end

      ST_DRAIN: begin
        // Swallow the rest of the truncated source frame; output stays idle.
        s0_axis_tready = ~w_owner_s1;
        s1_axis_tready =  w_owner_s1;
        if (w_src_valid && w_src_last) begin
          w_state_next      = ST_IDLE;
          w_grant_next      = 2'b00;
          w_last_grant_next = w_owner_s1;
        end
      end

      default: begin
        w_state_next = ST_IDLE;
        w_grant_next = 2'b00;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------
  always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
    if (s_axis_areset) begin
      r_state      <= ST_IDLE;
      r_grant      <= 2'b00;
      // Previous owner reads as s1 so that s0 wins the first tie.
      r_last_grant <= 1'b1;
      r_beat_cnt   <= '0;
      r_trunc      <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_grant      <= w_grant_next;
      r_last_grant <= w_last_grant_next;
      r_beat_cnt   <= w_beat_cnt_next;
      r_trunc      <= w_trunc_next;
    end
  end

  // Frame counters wrap naturally at 2^CNT_WIDTH.
  always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
    if (s_axis_areset) begin
      r_frame_cnt0 <= '0;
      r_frame_cnt1 <= '0;
    end else if (w_frame_done) begin
      if (w_owner_s1) begin
        r_frame_cnt1 <= r_frame_cnt1 + CNT_WIDTH'(1);
      end else begin
        r_frame_cnt0 <= r_frame_cnt0 + CNT_WIDTH'(1);
      end
    end
  end

  assign grant             = r_grant;
  assign status_frame_cnt0 = r_frame_cnt0;
  assign status_frame_cnt1 = r_frame_cnt1;
  assign status_trunc      = r_trunc;

endmodule

// File: tb/tb_axis_frame_arbiter.sv
// ---------------------------------------------------------------------------
// tb_axis_frame_arbiter
//
// Directed scoreboard bench. Expected output beats (data, tlast, owner and,
// where fixed, the cycle gap to the previous accepted beat) are queued when a
// frame is issued; a negedge monitor pops and compares each accepted output
// beat. DUT uses MAX_BEATS=5 so a 5-beat frame hits the limit exactly with
// its own tlast, and CNT_WIDTH=2 so frame counters wrap quickly.
// ---------------------------------------------------------------------------
module tb_axis_frame_arbiter;

  localparam int DW     = 16;
  localparam int MB     = 5;
  localparam int CW     = 2;
  localparam int BUDGET = 200;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] s0_tdata, s1_tdata, m_tdata;
  logic          s0_tvalid, s0_tlast, s0_tready;
  logic          s1_tvalid, s1_tlast, s1_tready;
  logic          m_tvalid, m_tlast, m_tready;
  logic [1:0]    grant;
  logic [CW-1:0] cnt0, cnt1;
  logic          status_trunc;

  always #5 clk = ~clk;

  axis_frame_arbiter #(
    .DATA_WIDTH (DW),
    .MAX_BEATS  (MB),
    .CNT_WIDTH  (CW)
  ) dut (
    .s_axis_aclk       (clk),
    .s_axis_areset     (rst),
    .s0_axis_tdata     (s0_tdata),
    .s0_axis_tvalid    (s0_tvalid),
    .s0_axis_tlast     (s0_tlast),
    .s0_axis_tready    (s0_tready),
    .s1_axis_tdata     (s1_tdata),
    .s1_axis_tvalid    (s1_tvalid),
    .s1_axis_tlast     (s1_tlast),
    .s1_axis_tready    (s1_tready),
    .m_axis_tdata      (m_tdata),
    .m_axis_tvalid     (m_tvalid),
    .m_axis_tlast      (m_tlast),
    .m_axis_tready     (m_tready),
    .grant             (grant),
    .status_frame_cnt0 (cnt0),
    .status_frame_cnt1 (cnt1),
    .status_trunc      (status_trunc)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
    logic [1:0]    grant;
    int            gap;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests      = 0;
  int   n_fail       = 0;
  int   cycle        = 0;
  int   prev_acc     = -100;
  int   trunc_pulses = 0;
  logic trunc_prev   = 1'b0;
  logic chk_mirror   = 1'b0;
  int   cnt0_seq[5]  = '{1, 2, 3, 0, 1};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_frame(input int src, input int nout, input logic [DW-1:0] base,
                            input int first_gap, input int rest_gap);
    exp_t e;
    for (int i = 0; i < nout; i++) begin
      e.data  = base + DW'(i);
      e.last  = (i == nout - 1);
      e.grant = (src == 0) ? 2'b01 : 2'b10;
      e.gap   = (i == 0) ? first_gap : rest_gap;
      exp_q.push_back(e);
    end
  endtask

  task automatic set_src(input int src, input logic v, input logic [DW-1:0] d, input logic l);
    if (src == 0) begin
      s0_tvalid = v; s0_tdata = d; s0_tlast = l;
    end else begin
      s1_tvalid = v; s1_tdata = d; s1_tlast = l;
    end
  endtask

  // Hold the current beat until it is accepted; returns at posedge+1.
  task automatic wait_hs(input int src);
    int   cyc = 0;
    logic hs  = 1'b0;
    while (!hs && cyc < BUDGET) begin
      @(negedge clk);
      hs = (src == 0) ? s0_tready : s1_tready;
      @(posedge clk);
      #1;
      cyc++;
    end
    if (!hs) begin
      n_tests++;
      n_fail++;
      $display("FAIL handshake_timeout: src %0d got no tready in %0d cycles, expected a handshake", src, BUDGET);
    end
  endtask

  task automatic drive_frame(input int src, input int n, input logic [DW-1:0] base);
    for (int i = 0; i < n; i++) begin
      set_src(src, 1'b1, base + DW'(i), (i == n - 1));
      wait_hs(src);
    end
    set_src(src, 1'b0, '0, 1'b0);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: one line per failing transaction, scoreboard pop per accepted beat.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      cycle++;
      if (rst) begin
        trunc_prev = 1'b0;
      end else begin
        if (status_trunc) begin
          trunc_pulses++;
          check("trunc_one_cycle", 32'(trunc_prev), 32'd0);
        end
        trunc_prev = status_trunc;
        if (chk_mirror && grant == 2'b10) begin
          check("s1_tready_mirror", 32'(s1_tready), 32'(m_tready));
          check("s0_tready_low", 32'(s0_tready), 32'd0);
        end
        if (m_tvalid && m_tready) begin
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_beat: got data 0x%0h, expected no beat", m_tdata);
          end else begin
            e = exp_q.pop_front();
            check("beat_data", 32'(m_tdata), 32'(e.data));
            check("beat_last", 32'(m_tlast), 32'(e.last));
            check("beat_grant", 32'(grant), 32'(e.grant));
            if (e.gap >= 0) check("beat_gap", 32'(cycle - prev_acc), 32'(e.gap));
          end
          prev_acc = cycle;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    m_tready = 1'b1;
    set_src(0, 1'b0, '0, 1'b0);
    set_src(1, 1'b0, '0, 1'b0);

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_m_tvalid", 32'(m_tvalid), 32'd0);
    check("rst_treadys", 32'({s0_tready, s1_tready}), 32'd0);
    check("rst_cnts", 32'({cnt0, cnt1}), 32'd0);
    check("rst_trunc", 32'(status_trunc), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_idle_tvalid", 32'(m_tvalid), 32'd0);
    @(posedge clk); #1;

    // Simultaneous requests after reset: s0 first, bubble, then s1.
    push_frame(0, 3, 16'h0100, -1, 1);
    push_frame(1, 3, 16'h0200, 2, 1);
    fork
      drive_frame(0, 3, 16'h0100);
      drive_frame(1, 3, 16'h0200);
    join
    idle_cycles(3);
    check("t030_cnt0", 32'(cnt0), 32'd1);
    check("t030_cnt1", 32'(cnt1), 32'd1);

    // s0 streaming back-to-back, s1 arrives mid-frame: s1 goes next.
    push_frame(0, 3, 16'h0300, -1, 1);
    push_frame(1, 2, 16'h0400, 2, 1);
    push_frame(0, 3, 16'h0500, 2, 1);
    fork
      begin
        drive_frame(0, 3, 16'h0300);
        drive_frame(0, 3, 16'h0500);
      end
      begin
        repeat (2) @(posedge clk);
        #1;
        drive_frame(1, 2, 16'h0400);
      end
    join
    idle_cycles(3);
    check("t031_cnt0", 32'(cnt0), 32'd3);
    check("t031_cnt1", 32'(cnt1), 32'd2);

    // Over-long frame: 5 beats out with forced tlast, 2 drained.
    push_frame(0, MB, 16'h0600, -1, 1);
    drive_frame(0, 7, 16'h0600);
    idle_cycles(2);
    @(negedge clk);
    check("t032_trunc_pulses", 32'(trunc_pulses), 32'd1);
    check("t032_grant_idle", 32'(grant), 32'd0);
    check("t032_cnt0_wrap", 32'(cnt0), 32'd0);
    @(posedge clk); #1;

    // Back-pressure toggling on an exactly MAX_BEATS-long s1 frame.
    push_frame(1, MB, 16'h0700, -1, -1);
    chk_mirror = 1'b1;
    begin
      logic done;
      done = 1'b0;
      fork
        begin
          drive_frame(1, MB, 16'h0700);
          done = 1'b1;
        end
        begin
          while (!done) begin
            @(posedge clk);
            #1;
            m_tready = ~m_tready;
          end
        end
      join
    end
    chk_mirror = 1'b0;
    m_tready = 1'b1;
    idle_cycles(2);
    check("t033_cnt1", 32'(cnt1), 32'd3);
    check("t033_no_trunc", 32'(trunc_pulses), 32'd1);

    // Reset during beat 2 of a 4-beat frame.
    begin
      exp_t e;
      e.data = 16'h0800; e.last = 1'b0; e.grant = 2'b01; e.gap = -1;
      exp_q.push_back(e);
    end
    set_src(0, 1'b1, 16'h0800, 1'b0);
    wait_hs(0);
    set_src(0, 1'b1, 16'h0801, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("t034_grant", 32'(grant), 32'd0);
    check("t034_m_tvalid", 32'(m_tvalid), 32'd0);
    check("t034_s0_tready", 32'(s0_tready), 32'd0);
    check("t034_cnts", 32'({cnt0, cnt1}), 32'd0);
    set_src(0, 1'b0, '0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Fresh s0 frames after release; counter wraps 1,2,3,0,1.
    for (int k = 0; k < 5; k++) begin
      push_frame(0, 2, 16'h0900 + DW'(16 * k), -1, 1);
      drive_frame(0, 2, 16'h0900 + DW'(16 * k));
      @(negedge clk);
      check("t035_cnt0", 32'(cnt0), 32'(cnt0_seq[k]));
      @(posedge clk); #1;
    end

    idle_cycles(3);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/axis_frame_arbiter.md
AXIS_FRAME_ARBITER -- requirements
Module: axis_frame_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64: width of every tdata bus.
REQ-002 SHALL have parameter MAX_BEATS, default 256: maximum number of beats forwarded per frame.
REQ-003 SHALL have parameter CNT_WIDTH, default 16: width of each frame counter.
REQ-004 SHALL have port s_axis_aclk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port s_axis_areset, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have ports s0_axis_tdata, input, DATA_WIDTH; s0_axis_tvalid, input, 1; s0_axis_tlast, input, 1; s0_axis_tready, output, 1: requester 0 stream.
REQ-007 SHALL have ports s1_axis_tdata, input, DATA_WIDTH; s1_axis_tvalid, input, 1; s1_axis_tlast, input, 1; s1_axis_tready, output, 1: requester 1 stream.
REQ-008 SHALL have ports m_axis_tdata, output, DATA_WIDTH; m_axis_tvalid, output, 1; m_axis_tlast, output, 1; m_axis_tready, input, 1: shared stream toward the 512-deep FIFO.
REQ-009 SHALL have port grant, output, 2 bits: one-hot current owner, bit0 = s0, bit1 = s1, 00 = none.
REQ-010 SHALL have ports status_frame_cnt0 and status_frame_cnt1, output, CNT_WIDTH each: frames forwarded per source.
REQ-011 SHALL have port status_trunc, output, 1 bit: one-cycle pulse when a frame is truncated.

Function
REQ-012 SHALL implement states IDLE, BUSY and DRAIN, plus a last_grant register.
REQ-013 IDLE: if exactly one source has tvalid=1, that source SHALL be selected; if both do, the source not equal to last_grant SHALL be selected.
REQ-014 IDLE: the selection SHALL be registered into grant with a transition to BUSY on the next edge; this is a fixed 1-cycle arbitration bubble during which all treadys and m_axis_tvalid are 0.
REQ-015 BUSY: m_axis_tdata, m_axis_tvalid and m_axis_tlast SHALL combinationally follow the granted source.
REQ-016 BUSY: the granted source's tready SHALL equal m_axis_tready, and the other source's tready SHALL be 0; there is no added data latency.
REQ-017 BUSY: a beat SHALL count as accepted when m_axis_tvalid and m_axis_tready are both 1, incrementing a beat counter of width clog2(MAX_BEATS+1).
REQ-018 BUSY: an accepted beat with tlast=1 SHALL move the block to IDLE, set last_grant to the granted source, clear grant and the beat counter, and increment that source's frame counter.
REQ-019 BUSY: when the accepted beat is the MAX_BEATS-th and source tlast=0, m_axis_tlast SHALL be forced to 1 on that beat.
REQ-020 On that forced-tlast beat the block SHALL pulse status_trunc for one cycle, increment the source's frame counter, and move to DRAIN.
REQ-021 If the MAX_BEATS-th beat already carries tlast=1, it SHALL be handled as a normal frame end (REQ-018) with no truncation.
REQ-022 DRAIN: m_axis_tvalid SHALL be 0, and the granted source's tready SHALL be 1 so its beats are discarded.
REQ-023 DRAIN: when a discarded beat has tlast=1, the block SHALL move to IDLE, update last_grant and clear grant; discarded beats SHALL NOT be counted.
REQ-024 The non-granted source's tvalid SHALL have no effect outside IDLE; a frame SHALL never be interleaved.
REQ-025 Frame counters SHALL wrap from 2^CNT_WIDTH-1 to 0.
REQ-026 m_axis_tready=0 in BUSY SHALL stall without changing state or counters; source data is held by the AXI-Stream rules of the source.

Reset
REQ-027 Asserting s_axis_areset SHALL immediately force: state IDLE; grant=00; last_grant=s1, so s0 wins the first tie; beat counter, frame counters and status_trunc = 0.
REQ-028 While s_axis_areset is asserted and until the first arbitration, m_axis_tvalid, s0_axis_tready and s1_axis_tready SHALL be 0.
REQ-029 Reset mid-frame SHALL abandon the frame; no partial state SHALL survive, and the next frame after release is arbitrated from IDLE.

Verification
REQ-030 Both sources valid after reset, 3-beat frames each, m_axis_tready=1 -> s0 frame forwarded first, 1-cycle bubble, then s1; frame_cnt0=1, frame_cnt1=1.
REQ-031 s0 continuously offering frames, s1 idle, then s1 offers -> after the current s0 frame ends, s1 is granted next (round-robin), not s0.
REQ-032 MAX_BEATS=4, s0 sends a 7-beat frame -> 4 beats out with tlast on beat 4, status_trunc pulses once, 3 beats absorbed with m_axis_tvalid=0, grant returns to 00.
REQ-033 m_axis_tready toggled 1/0 every cycle during a 5-beat s1 frame -> all 5 beats out in order, s1_axis_tready mirrors m_axis_tready, s0_axis_tready stays 0.
REQ-034 s_axis_areset asserted on beat 2 of a 4-beat frame -> same cycle grant=00, m_axis_tvalid=0, counters=0; after release a new s0 frame forwards normally.
REQ-035 Frame counters preset near wrap, CNT_WIDTH=2, 5 frames on s0 -> status_frame_cnt0 sequence 1,2,3,0,1.
